// File: rtl/mem_access_seq_if.sv
// rtl/mem_access_seq_if.sv - request/response and memory-port bundle for mem_access_seq
//
// Purpose: groups the cpu-side request/response handshake and the memory port.
// Ports (signals):
//   req_valid/req_ready/req_op/req_indirect/req_addr/req_wdata : request handshake
//   rsp_valid/rsp_rdata/rsp_err                                 : completion pulse
//   mem_address/mem_read/mem_write/mem_byte_enable/mem_wdata     : memory strobes
//   mem_rdata/mem_resp                                          : memory response
// Modports: master = sequencer side, slave = cpu + memory side.
interface mem_access_seq_if #(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 16,
  parameter int MAX_INDIRECT = 2
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int IW    = (MAX_INDIRECT > 0) ? $clog2(MAX_INDIRECT + 1) : 1;

  logic                  req_valid;
  logic                  req_ready;
  logic [1:0]            req_op;
  logic [IW-1:0]         req_indirect;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;

  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;

  logic [ADDR_WIDTH-1:0] mem_address;
  logic                  mem_read;
  logic                  mem_write;
  logic [BYTES-1:0]      mem_byte_enable;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_resp;

  modport master (
    input  req_valid, req_op, req_indirect, req_addr, req_wdata, mem_rdata, mem_resp,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata
  );

  modport slave (
    output req_valid, req_op, req_indirect, req_addr, req_wdata, mem_rdata, mem_resp,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata
  );
endinterface

// File: rtl/mem_access_seq.sv
// rtl/mem_access_seq.sv - multicycle memory-transaction sequencer with pointer dereference and timeout
//
// Purpose: accepts one word/byte read or write, optionally follows up to
// MAX_INDIRECT pointers first, issues each memory access as a held strobe
// until mem_resp, and reports completion (or timeout abort) as a one-cycle pulse.
// Ports:
//   clk   : clock, all state on rising edge
//   rst_n : synchronous active-low reset
//   bus   : mem_access_seq_if.master (request, response and memory port)
module mem_access_seq #(
  parameter int DATA_WIDTH     = 16,
  parameter int ADDR_WIDTH     = 16,
  parameter int MAX_INDIRECT   = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic               clk,
  input logic               rst_n,
  mem_access_seq_if.master  bus
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int LSB   = $clog2(BYTES);
  localparam int IW    = (MAX_INDIRECT > 0) ? $clog2(MAX_INDIRECT + 1) : 1;
  localparam int TW    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam logic [ADDR_WIDTH-1:0] LANE_MASK = ADDR_WIDTH'((1 << LSB) - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PTR  = 3'd1;
  localparam logic [2:0] S_GAP  = 3'd2;
  localparam logic [2:0] S_ACC  = 3'd3;
  localparam logic [2:0] S_RESP = 3'd4;

  logic [2:0]            state;
  logic [1:0]            op;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [IW-1:0]         count;
  logic [TW-1:0]         tcnt;
  logic [DATA_WIDTH-1:0] result;
  logic                  err;

  logic                  is_write;
  logic                  is_byte;
  logic [ADDR_WIDTH-1:0] lane;
  logic [ADDR_WIDTH-1:0] word_addr;
  logic [IW-1:0]         sat_indirect;
  logic                  timed_out;
  logic [DATA_WIDTH-1:0] rd_shift;

  assign is_write  = op[0];
  assign is_byte   = op[1];
  assign lane      = addr & LANE_MASK;
  assign word_addr = addr & ~LANE_MASK;
  assign rd_shift  = bus.mem_rdata >> {lane, 3'b000};

  // Over-range dereference counts clamp rather than wrap.
  assign sat_indirect = (bus.req_indirect > IW'(MAX_INDIRECT)) ? IW'(MAX_INDIRECT)
                                                               : bus.req_indirect;

  // tcnt counts strobe cycles already spent without mem_resp; the limit-th
  // cycle aborts unless mem_resp arrives in that same cycle.
  assign timed_out = (TIMEOUT_CYCLES != 0) && (tcnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      op     <= '0;
      addr   <= '0;
      wdata  <= '0;
      count  <= '0;
      tcnt   <= '0;
      result <= '0;
      err    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            op     <= bus.req_op;
            addr   <= bus.req_addr;
            wdata  <= bus.req_wdata;
            count  <= sat_indirect;
            tcnt   <= '0;
            result <= '0;
            err    <= 1'b0;
            state  <= (sat_indirect != '0) ? S_PTR : S_ACC;
          end
        end
        S_PTR: begin
          if (bus.mem_resp) begin
            addr  <= ADDR_WIDTH'(bus.mem_rdata);
            count <= count - 1'b1;
            tcnt  <= '0;
            state <= S_GAP;
          end else if (timed_out) begin
            err    <= 1'b1;
            result <= '0;
            state  <= S_RESP;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        S_GAP: begin
          tcnt  <= '0;
          state <= (count != '0) ? S_PTR : S_ACC;
        end
        S_ACC: begin
          if (bus.mem_resp) begin
            if (is_write)     result <= '0;
            else if (is_byte) result <= DATA_WIDTH'(rd_shift[7:0]);
            else              result <= bus.mem_rdata;
            state <= S_RESP;
          end else if (timed_out) begin
            err    <= 1'b1;
            result <= '0;
            state  <= S_RESP;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.req_ready       = (state == S_IDLE);
    bus.rsp_valid       = (state == S_RESP);
    bus.rsp_err         = (state == S_RESP) && err;
    bus.rsp_rdata       = (state == S_RESP) ? result : '0;
    bus.mem_read        = 1'b0;
    bus.mem_write       = 1'b0;
    bus.mem_address     = '0;
    bus.mem_byte_enable = '0;
    bus.mem_wdata       = '0;
    if (state == S_PTR) begin
      bus.mem_read        = 1'b1;
      bus.mem_address     = word_addr;
      bus.mem_byte_enable = '1;
    end else if (state == S_ACC) begin
      bus.mem_read  = !is_write;
      bus.mem_write = is_write;
      if (is_byte) begin
        bus.mem_address     = addr;
        bus.mem_byte_enable = BYTES'(1) << lane;
        if (is_write) bus.mem_wdata = DATA_WIDTH'(wdata[7:0]) << {lane, 3'b000};
      end else begin
        bus.mem_address     = word_addr;
        bus.mem_byte_enable = '1;
        if (is_write) bus.mem_wdata = wdata;
      end
    end
  end
endmodule

// File: tb/tb_mem_access_seq.sv
// tb/tb_mem_access_seq.sv - directed self-checking bench for mem_access_seq
//
// Purpose: drives requests through the interface, models a memory with a
// configurable wait count, and checks strobes, latency and responses.
// Ports: none (top-level bench).
module tb_mem_access_seq;
  logic clk;
  logic rst_n;

  mem_access_seq_if #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .MAX_INDIRECT(2)) bus ();

  mem_access_seq #(
    .DATA_WIDTH(16), .ADDR_WIDTH(16), .MAX_INDIRECT(2), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // memory model: read-only word array, indexed by address[15:1]
  logic [15:0] mem_model [0:32767];
  int          wait_cfg = 0;
  bit          mem_enable = 1'b1;
  bit          force_resp = 1'b0;
  int          wcnt = 0;

  always @(negedge clk) begin
    if (force_resp) begin
      bus.mem_resp  = 1'b1;
      bus.mem_rdata = 16'hDEAD;
      wcnt = 0;
    end else if ((bus.mem_read || bus.mem_write) && mem_enable) begin
      if (wcnt >= wait_cfg) begin
        bus.mem_resp  = 1'b1;
        bus.mem_rdata = mem_model[bus.mem_address[15:1]];
        wcnt = 0;
      end else begin
        bus.mem_resp  = 1'b0;
        bus.mem_rdata = 16'h0000;
        wcnt++;
      end
    end else begin
      bus.mem_resp  = 1'b0;
      bus.mem_rdata = 16'h0000;
      wcnt = 0;
    end
  end

  // monitor: cumulative counters, tests take deltas
  int          rd_cycles = 0;
  int          wr_cycles = 0;
  logic [15:0] addr_log [$];
  logic [1:0]  last_be = 2'b00;
  logic [15:0] last_wdata = 16'h0000;
  bit          prev_strobe = 1'b0;

  always @(negedge clk) begin
    if ((bus.mem_read || bus.mem_write) && !prev_strobe) addr_log.push_back(bus.mem_address);
    if (bus.mem_read) rd_cycles++;
    if (bus.mem_write) begin
      wr_cycles++;
      last_be    = bus.mem_byte_enable;
      last_wdata = bus.mem_wdata;
    end
    prev_strobe = bus.mem_read || bus.mem_write;
  end

  // lat = negedges from the accept cycle to the rsp_valid cycle
  task automatic do_txn(input logic [1:0] op, input logic [1:0] ind, input logic [15:0] addr,
                        input logic [15:0] wdata, output int lat, output logic [15:0] rdata,
                        output logic err, output logic next_valid, output logic next_ready);
    @(negedge clk);
    bus.req_op = op; bus.req_indirect = ind; bus.req_addr = addr; bus.req_wdata = wdata;
    bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.rsp_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    rdata = bus.rsp_rdata;
    err   = bus.rsp_err;
    @(negedge clk);
    next_valid = bus.rsp_valid;
    next_ready = bus.req_ready;
  endtask

  task automatic test_reset();
    int anomalies;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", bus.req_ready); end
    total++; if ({bus.mem_read, bus.mem_write, bus.rsp_valid, bus.rsp_err} !== 4'b0000) begin bad++; $display("FAIL reset_strobes got=%b exp=0000", {bus.mem_read, bus.mem_write, bus.rsp_valid, bus.rsp_err}); end
    total++; if (bus.mem_byte_enable !== 2'b00) begin bad++; $display("FAIL reset_be got=%b exp=00", bus.mem_byte_enable); end
    total++; if ({bus.mem_address, bus.mem_wdata, bus.rsp_rdata} !== 48'h0) begin bad++; $display("FAIL reset_buses got=%h exp=0", {bus.mem_address, bus.mem_wdata, bus.rsp_rdata}); end
    rst_n = 1'b1;
    // reset in the middle of a stalled read
    mem_enable = 1'b0;
    @(negedge clk);
    bus.req_op = 2'b00; bus.req_indirect = 2'd0; bus.req_addr = 16'h0040; bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    total++; if (bus.mem_read !== 1'b1) begin bad++; $display("FAIL midreset_busy got=%b exp=1", bus.mem_read); end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL midreset_ready got=%b exp=1", bus.req_ready); end
    total++; if ({bus.mem_read, bus.mem_write, bus.rsp_valid, bus.mem_byte_enable} !== 5'b0) begin bad++; $display("FAIL midreset_outs got=%b exp=00000", {bus.mem_read, bus.mem_write, bus.rsp_valid, bus.mem_byte_enable}); end
    rst_n = 1'b1;
    mem_enable = 1'b1;
    force_resp = 1'b1;
    anomalies = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b0 || bus.mem_read !== 1'b0 || bus.req_ready !== 1'b1) anomalies++;
    end
    force_resp = 1'b0;
    total++; if (anomalies !== 0) begin bad++; $display("FAIL stray_resp_ignored got=%0d exp=0", anomalies); end
  endtask

  task automatic test_read_word();
    int lat; logic [15:0] rd; logic err, nv, nr; int rd0; int a0;
    wait_cfg = 3;
    mem_model[16'h0040 >> 1] = 16'h1234;
    rd0 = rd_cycles; a0 = addr_log.size();
    do_txn(2'b00, 2'd0, 16'h0040, 16'h0, lat, rd, err, nv, nr);
    total++; if (rd_cycles - rd0 !== 4) begin bad++; $display("FAIL rw_read_cycles got=%0d exp=4", rd_cycles - rd0); end
    total++; if (addr_log.size() != a0 + 1 || addr_log[a0] !== 16'h0040) begin bad++; $display("FAIL rw_addr got=%h exp=0040", (addr_log.size() > a0) ? addr_log[a0] : 16'hxxxx); end
    total++; if (rd !== 16'h1234) begin bad++; $display("FAIL rw_rdata got=%h exp=1234", rd); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL rw_err got=%b exp=0", err); end
    total++; if (lat !== 5) begin bad++; $display("FAIL rw_latency got=%0d exp=5", lat); end
    total++; if (nv !== 1'b0 || nr !== 1'b1) begin bad++; $display("FAIL rw_pulse got=%b%b exp=01", nv, nr); end
    wait_cfg = 0;
  endtask

  task automatic test_byte_ops();
    int lat; logic [15:0] rd; logic err, nv, nr; int wr0;
    wr0 = wr_cycles;
    do_txn(2'b11, 2'd0, 16'h0051, 16'h00AB, lat, rd, err, nv, nr);
    total++; if (wr_cycles - wr0 !== 1) begin bad++; $display("FAIL wb_cycles got=%0d exp=1", wr_cycles - wr0); end
    total++; if (last_be !== 2'b10) begin bad++; $display("FAIL wb_be got=%b exp=10", last_be); end
    total++; if (last_wdata !== 16'hAB00) begin bad++; $display("FAIL wb_wdata got=%h exp=AB00", last_wdata); end
    total++; if (rd !== 16'h0000 || err !== 1'b0) begin bad++; $display("FAIL wb_rsp got=%h/%b exp=0000/0", rd, err); end
    wr0 = wr_cycles;
    do_txn(2'b01, 2'd0, 16'h0061, 16'h5AA5, lat, rd, err, nv, nr);
    total++; if (last_be !== 2'b11 || last_wdata !== 16'h5AA5) begin bad++; $display("FAIL ww_bus got=%b/%h exp=11/5AA5", last_be, last_wdata); end
    mem_model[16'h0050 >> 1] = 16'hCD12;
    do_txn(2'b10, 2'd0, 16'h0051, 16'h0, lat, rd, err, nv, nr);
    total++; if (rd !== 16'h00CD) begin bad++; $display("FAIL rb_hi got=%h exp=00CD", rd); end
    do_txn(2'b10, 2'd0, 16'h0050, 16'h0, lat, rd, err, nv, nr);
    total++; if (rd !== 16'h0012) begin bad++; $display("FAIL rb_lo got=%h exp=0012", rd); end
  endtask

  task automatic test_indirect();
    int lat; logic [15:0] rd; logic err, nv, nr; int a0;
    mem_model[16'h0100 >> 1] = 16'h0200;
    mem_model[16'h0200 >> 1] = 16'h0301;
    mem_model[16'h0300 >> 1] = 16'hBEEF;
    a0 = addr_log.size();
    do_txn(2'b00, 2'd2, 16'h0100, 16'h0, lat, rd, err, nv, nr);
    total++; if (addr_log.size() - a0 !== 3) begin bad++; $display("FAIL ind_starts got=%0d exp=3", addr_log.size() - a0); end
    if (addr_log.size() - a0 == 3) begin
      total++; if ({addr_log[a0], addr_log[a0+1], addr_log[a0+2]} !== 48'h0100_0200_0300) begin bad++; $display("FAIL ind_addrs got=%h exp=010002000300", {addr_log[a0], addr_log[a0+1], addr_log[a0+2]}); end
    end
    total++; if (rd !== 16'hBEEF) begin bad++; $display("FAIL ind_rdata got=%h exp=BEEF", rd); end
    total++; if (lat + 1 !== 7) begin bad++; $display("FAIL ind_latency got=%0d exp=7", lat + 1); end
  endtask

  task automatic test_timeout();
    int lat; logic [15:0] rd; logic err, nv, nr; int rd0;
    mem_enable = 1'b0;
    rd0 = rd_cycles;
    do_txn(2'b00, 2'd0, 16'h0040, 16'h0, lat, rd, err, nv, nr);
    total++; if (rd_cycles - rd0 !== 8) begin bad++; $display("FAIL to_read_cycles got=%0d exp=8", rd_cycles - rd0); end
    total++; if (err !== 1'b1 || rd !== 16'h0000) begin bad++; $display("FAIL to_rsp got=%b/%h exp=1/0000", err, rd); end
    total++; if (lat !== 9) begin bad++; $display("FAIL to_latency got=%0d exp=9", lat); end
    total++; if (nr !== 1'b1 || nv !== 1'b0) begin bad++; $display("FAIL to_ready_after got=%b%b exp=10", nr, nv); end
    mem_enable = 1'b1;
  endtask

  task automatic test_saturate();
    int lat; logic [15:0] rd; logic err, nv, nr; int a0;
    mem_model[16'h0400 >> 1] = 16'h0500;
    mem_model[16'h0500 >> 1] = 16'h0600;
    mem_model[16'h0600 >> 1] = 16'h1111;
    mem_model[16'h1110 >> 1] = 16'h2222;
    a0 = addr_log.size();
    do_txn(2'b00, 2'd3, 16'h0400, 16'h0, lat, rd, err, nv, nr);
    total++; if (addr_log.size() - a0 !== 3) begin bad++; $display("FAIL sat_starts got=%0d exp=3", addr_log.size() - a0); end
    total++; if (rd !== 16'h1111) begin bad++; $display("FAIL sat_rdata got=%h exp=1111", rd); end
  endtask

  task automatic test_back_to_back();
    int n; int ready_busy; logic [15:0] rd_a, rd_b; logic ready_after; int a0;
    wait_cfg = 3;
    a0 = addr_log.size();
    @(negedge clk);
    bus.req_op = 2'b00; bus.req_indirect = 2'd0; bus.req_addr = 16'h0040; bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_addr = 16'h0300;
    n = 0; ready_busy = 0;
    while (!bus.rsp_valid && n < 50) begin
      if (bus.req_ready !== 1'b0) ready_busy++;
      @(negedge clk);
      n++;
    end
    rd_a = bus.rsp_rdata;
    total++; if (ready_busy !== 0 || n >= 50) begin bad++; $display("FAIL b2b_ready_busy got=%0d exp=0", ready_busy); end
    total++; if (rd_a !== 16'h1234) begin bad++; $display("FAIL b2b_first_rdata got=%h exp=1234", rd_a); end
    @(negedge clk);
    ready_after = bus.req_ready;
    @(negedge clk);
    bus.req_valid = 1'b0;
    n = 0;
    while (!bus.rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    rd_b = bus.rsp_rdata;
    total++; if (ready_after !== 1'b1) begin bad++; $display("FAIL b2b_ready_after got=%b exp=1", ready_after); end
    total++; if (rd_b !== 16'hBEEF) begin bad++; $display("FAIL b2b_second_rdata got=%h exp=BEEF", rd_b); end
    total++; if (addr_log.size() - a0 !== 2) begin bad++; $display("FAIL b2b_starts got=%0d exp=2", addr_log.size() - a0); end
    @(negedge clk);
    wait_cfg = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_op = 2'b00; bus.req_indirect = 2'd0;
    bus.req_addr = 16'h0; bus.req_wdata = 16'h0;
    for (int i = 0; i < 32768; i++) mem_model[i] = 16'h0000;
    test_reset();
    test_read_word();
    test_byte_ops();
    test_indirect();
    test_timeout();
    test_saturate();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
